// File: rtl/image_mem_top.sv
// Ping-pong image buffer: two 32 x 8-bit flip-flop banks, one written while the other is read.
// Latency: write lands on the clock edge; read data is registered, one cycle after addr2/sel.
// Backpressure: none; writes and reads are accepted every cycle with no stall.
module image_mem_top #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic              wr,
  input  logic              sel,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Flip-flop storage so both banks can be cleared by the asynchronous reset.
  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  // sel is used combinationally on each edge, with no swap register, so a
  // toggle redirects both the write and the read on the very next edge.
  logic we0;
  logic we1;

  assign we0 = wr & ~sel;
  assign we1 = wr &  sel;

  // Bank 0: cleared on reset, written only while it is the write bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank0[i] <= '0;
      end
    end else if (we0) begin
      bank0[addr1] <= wdata;
    end
  end

  // Bank 1: cleared on reset, written only while it is the write bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank1[i] <= '0;
      end
    end else if (we1) begin
      bank1[addr1] <= wdata;
    end
  end

  // Registered read from the bank opposite to the write bank. Same-edge
  // reads and writes never touch the same bank, so no bypass is needed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (sel) begin
      rdata <= bank0[addr2];
    end else begin
      rdata <= bank1[addr2];
    end
  end

endmodule

// File: tb/tb_image_mem_top.sv
// Bench for the ping-pong image buffer: directed vectors, expected rdata queued per read.
// A monitor on the falling edge pops and compares each entry in the cycle it is due.
// Asynchronous reset behaviour is compared directly, away from any clock edge.
module tb_image_mem_top;

  logic       clk;
  logic       rstn;
  logic [4:0] addr1;
  logic [4:0] addr2;
  logic       wr;
  logic       sel;
  logic [7:0] wdata;
  logic [7:0] rdata;

  image_mem_top #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .addr1 (addr1),
    .addr2 (addr2),
    .wr    (wr),
    .sel   (sel),
    .wdata (wdata),
    .rdata (rdata)
  );

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t item;
  int       cyc    = 0;
  int       checks = 0;
  int       passes = 0;

  // 20 ns clock period
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Edge counter used to decide when a queued expectation is due
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: rdata=0x%02h expected 0x%02h", name, act, exp);
  endtask

  // Monitor: compare every due expectation on the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      item = sb.pop_front();
      if (item.due == cyc) begin
        check(item.name, rdata, item.exp);
      end else begin
        checks++;
        $display("FAIL %s: result missed, due cycle %0d now %0d", item.name, item.due, cyc);
      end
    end
  end

  // One clock cycle of stimulus; optionally queue the rdata expected after the edge
  task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic w,
                      input logic s, input logic [7:0] d, input logic chk,
                      input logic [7:0] exp, input string name);
    sb_item_t e;
    addr1 = a1;
    addr2 = a2;
    wr    = w;
    sel   = s;
    wdata = d;
    if (chk) begin
      e.due  = cyc + 1;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    addr1 = '0;
    addr2 = '0;
    wr    = 1'b1;
    sel   = 1'b0;
    wdata = 8'hEE;

    // Reset held for 20 ns; wr asserted during reset must be ignored
    rstn = 1'b0;
    #5;
    check("reset_rdata", rdata, 8'h00);
    #15;
    rstn = 1'b1;

    // Both banks read back zero after reset
    step(5'd0,  5'd0,  1'b0, 1'b0, 8'h00, 1'b1, 8'h00, "rst_b1_a0");
    step(5'd0,  5'd31, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, "rst_b1_a31");
    step(5'd0,  5'd0,  1'b0, 1'b1, 8'h00, 1'b1, 8'h00, "rst_b0_a0");
    step(5'd0,  5'd31, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, "rst_b0_a31");

    // Fill bank0 with k+0x10 while reading bank1, which must stay zero
    for (int k = 0; k < 32; k++) begin
      step(5'(k), 5'(k), 1'b1, 1'b0, 8'(k + 16), 1'b1, 8'h00, "fill_rd_b1");
    end

    // Swap: read bank0 back, rdata = addr2 + 0x10
    for (int k = 0; k < 32; k++) begin
      step(5'd0, 5'(k), 1'b0, 1'b1, 8'h00, 1'b1, 8'(k + 16), "sweep_b0");
    end

    // wr=0 with wdata=0xFF across every address of bank0: nothing changes
    for (int k = 0; k < 32; k++) begin
      step(5'(k), 5'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, "");
    end
    for (int k = 0; k < 32; k++) begin
      step(5'd0, 5'(k), 1'b0, 1'b1, 8'h00, 1'b1, 8'(k + 16), "hold_b0");
    end
    // Bank1 was also the write bank's peer with wr=0; still zero
    step(5'd0, 5'd7, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, "hold_b1");

    // Leave a nonzero value on rdata, then pulse reset for 5 ns between edges
    step(5'd0, 5'd31, 1'b0, 1'b1, 8'h00, 1'b1, 8'h2F, "pre_reset");
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrun_reset_rdata", rdata, 8'h00);
    #4;
    rstn = 1'b1;

    // Every entry of both banks is zero again
    for (int k = 0; k < 32; k++) begin
      step(5'd0, 5'(k), 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, "clr_b0");
    end
    for (int k = 0; k < 32; k++) begin
      step(5'd0, 5'(k), 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, "clr_b1");
    end

    // Isolation: write bank0[5]=0xAA while reading bank1[5]
    step(5'd5, 5'd5, 1'b1, 1'b0, 8'hAA, 1'b1, 8'h00, "iso_same_edge");
    step(5'd0, 5'd5, 1'b0, 1'b1, 8'h00, 1'b1, 8'hAA, "iso_swap");

    // Ping-pong: write bank1[3]=0x55 while reading bank0[3]
    step(5'd3, 5'd3, 1'b1, 1'b1, 8'h55, 1'b1, 8'h00, "pp_rd_b0");
    step(5'd0, 5'd3, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, "pp_swap");
    // Bank0 kept its earlier data
    step(5'd0, 5'd5, 1'b0, 1'b1, 8'h00, 1'b1, 8'hAA, "pp_b0_kept");
    step(5'd0, 5'd3, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, "pp_b0_a3");

    // Drain and make sure nothing is left outstanding
    step(5'd0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "");
    step(5'd0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "");
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
